v2f_alu_sched: RTL and testbench
================================

Name: v2f_alu_sched

Overview:
- Round-robin scheduler that shares one pipelined v2f arithmetic/logic combinator among N_REQ requesters.
- Accepts one operation per cycle and drives the shared unit's op/operand ports.
- Tracks requester tags through a LATENCY-deep shift register and routes each result back to the requester that issued it.
- Sits between mapped v2f_add/sub/mul/div/mod/and/or/xor/shl/shr consumers and a single time-multiplexed combinator.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- LATENCY, 1: fixed cycles from shared-unit issue to result, 1..8.
- DATA_W, 32: operand/result width; must be ≤32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_op  in  4*N_REQ  per-requester opcode (package enum v2f_op_t).
- req_a  in  DATA_W*N_REQ  per-requester operand A.
- req_b  in  DATA_W*N_REQ  per-requester operand B.
- req_ready  out  N_REQ  one-hot grant; transfer when valid&ready.
- alu_valid  out  1  issue strobe to the shared unit.
- alu_op  out  4  opcode to the shared unit.
- alu_a  out  DATA_W  operand A to the shared unit.
- alu_b  out  DATA_W  operand B to the shared unit.
- alu_y  in  DATA_W  shared-unit result, valid LATENCY cycles after issue.
- rsp_valid  out  N_REQ  one-hot result strobe.
- rsp_data  out  DATA_W  result, broadcast to all requesters.
- flush  in  1  stop issuing and drain the pipeline.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  high while any tag is in flight or the state is not IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, tag pipe cleared. req_ready, alu_valid, rsp_valid, flush_done and busy all 0. alu_op/alu_a/alu_b/rsp_data=0.
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN when any req_valid is high and flush is low.
  - RUN→IDLE when no req_valid is high and the pipe is empty.
  - RUN or IDLE→DRAIN when flush is high.
  - DRAIN→IDLE when the pipe is empty; flush_done pulses in that same cycle.
  - DRAIN with the pipe already empty exits in one cycle.
- Arbitration is combinational in IDLE and RUN.
  - Grant the first valid requester searching from rr_ptr upward, with wrap-around.
  - req_ready is one-hot, or zero when no requester is valid or state=DRAIN.
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
- Issue is registered. On grant of requester i, next cycle alu_valid=1 and alu_op/a/b hold requester i's fields.
- On grant, rr_ptr := (i+1) mod N_REQ. rr_ptr is unchanged when nothing is granted.
- Throughput: one issue per cycle. A requester continuously valid alone is granted every cycle.
- Tag pipe: LATENCY+1 stages of {valid, tag[$clog2(N_REQ)-1:0]}. The +1 covers the issue register.
  - Stage 0 loads on grant; the tail drives rsp_valid = valid ? onehot(tag) : 0.
  - rsp_data = alu_y, sampled combinationally in the same cycle as the tail stage.
  - Response latency: exactly LATENCY+1 cycles from the req_valid&req_ready edge to rsp_valid.
- Responses cannot be back-pressured; requesters must always accept rsp_valid.
- flush asserted the same cycle as a grant: the flush wins, no grant is made, and the state goes to DRAIN.
- In-flight results during DRAIN are still delivered.
- Div/mod by zero is issued unchanged; the shared unit defines the result (0).
- Reset mid-operation: all in-flight tags are discarded; no rsp_valid is produced after reset.
- busy = (state!=IDLE) | any pipe stage valid.

Optional Feature:
- Macro V2F_ALU_SCHED_PERF_EN.
- Defined: adds output perf_grants (32*N_REQ), one saturating 32-bit grant counter per requester, plus output perf_conflict (32), which counts cycles where ≥2 requesters are valid. Both counters clear on reset and on flush_done.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Package v2f_sched_pkg holds:
  - v2f_op_t (ADD=0, SUB, MUL, DIV, MOD, AND, OR, XOR, SHL, SHR);
  - sched_state_t;
  - localparam MAX_LATENCY=8;
  - function onehot_of(tag).
- One sub-module, v2f_rr_arbiter: N-way round-robin, combinational grant plus registered pointer. The FSM, issue register and tag pipe stay in v2f_alu_sched.

Test Plan:
- Reset then a single request: rst pulse; requester 2 requests ADD a=5 b=7 with LATENCY=1. Required: req_ready=0100 in the request cycle, alu_valid with op=ADD a=5 b=7 next cycle, rsp_valid=0100 with rsp_data=12 two cycles after the grant.
- Fairness: all 4 requesters valid for 8 cycles starting from rr_ptr=0. Required: grant order 0,1,2,3,0,1,2,3, and each response is tagged to the matching requester.
- Back-to-back with LATENCY=3: requester 1 issues MUL 3*4, then DIV 9/0 on consecutive cycles. Required: rsp_valid=0010 with data 12, then 0010 with data 0, on consecutive cycles at offsets 4 and 5.
- Flush with traffic: 3 ops are in flight (LATENCY=3), then flush is raised together with req_valid=1111. Required: no grant, all 3 responses are delivered, flush_done pulses once after the last one, then the state is IDLE.
- Async reset mid-flight: rst is raised while 2 tags are in the pipe. Required: all outputs are 0 immediately, and no rsp_valid appears after release.
- PERF_EN build: 10 cycles with requesters 0 and 1 both valid. Required: perf_grants[0]=5, perf_grants[1]=5, perf_conflict=10, and all counters read 0 after flush_done.

Source files
------------

// File: rtl/v2f_sched_pkg.sv
// Shared types for the v2f ALU scheduler: opcodes, FSM states and the
// tag-to-requester one-hot decode.
package v2f_sched_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    MOD = 4'd4,
    AND = 4'd5,
    OR  = 4'd6,
    XOR = 4'd7,
    SHL = 4'd8,
    SHR = 4'd9
  } v2f_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int unsigned MAX_LATENCY = 8;
  localparam int unsigned MAX_REQ     = 8;

  function automatic logic [MAX_REQ-1:0] onehot_of(input logic [2:0] tag);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[tag] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/v2f_alu_sched_arb.sv
// N-way round-robin arbiter: combinational one-hot grant searched upward
// from a registered pointer, which moves past the winner on every grant.
module v2f_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  always_comb begin
    logic          found;
    logic [IW-1:0] sel;
    int unsigned   idx;
    found       = 1'b0;
    sel         = '0;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    ptr_d       = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      sel = IW'(idx);
      if (en_i && !found && req_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        grant_idx_o  = sel;
        ptr_d        = IW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/v2f_alu_sched.sv
// Round-robin scheduler sharing one pipelined v2f combinator among N_REQ
// requesters. Optional counters: define V2F_ALU_SCHED_PERF_EN.
module v2f_alu_sched
  import v2f_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [4*N_REQ-1:0]    req_op,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  alu_valid,
  output logic [3:0]            alu_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_y,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy
`ifdef V2F_ALU_SCHED_PERF_EN
  ,
  output logic [32*N_REQ-1:0]   perf_grants,
  output logic [31:0]           perf_conflict
`endif
);

  localparam int unsigned TAG_W = $clog2(N_REQ);

  sched_state_t      state_q;
  logic              arb_en;
  logic [N_REQ-1:0]  grant;
  logic [TAG_W-1:0]  grant_idx;
  logic              any_valid;
  logic              pipe_empty;

  logic [LATENCY:0]  pipe_vld_q;
  logic [TAG_W-1:0]  pipe_tag_q [LATENCY+1];

  logic [3:0]        op_arr [N_REQ];
  logic [DATA_W-1:0] a_arr  [N_REQ];
  logic [DATA_W-1:0] b_arr  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[4*g +: 4];
    assign a_arr[g]  = req_a[DATA_W*g +: DATA_W];
    assign b_arr[g]  = req_b[DATA_W*g +: DATA_W];
  end

  assign any_valid  = |req_valid;
  assign pipe_empty = ~|pipe_vld_q;
  // Flush outranks a same-cycle grant; rst gating keeps ready low during reset.
  assign arb_en     = (state_q != DRAIN) & ~flush & ~rst;

  v2f_rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .en_i        (arb_en),
    .req_i       (req_valid),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush)          state_q <= DRAIN;
          else if (any_valid) state_q <= RUN;
        end
        RUN: begin
          if (flush)                          state_q <= DRAIN;
          else if (!any_valid && pipe_empty)  state_q <= IDLE;
        end
        DRAIN: begin
          if (pipe_empty) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      alu_valid <= |grant;
      if (|grant) begin
        alu_op <= op_arr[grant_idx];
        alu_a  <= a_arr[grant_idx];
        alu_b  <= b_arr[grant_idx];
      end
    end
  end

  // Stage 0 shadows the issue register, so the tail lines up with alu_y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i <= LATENCY; i++) pipe_tag_q[i] <= '0;
    end else begin
      pipe_vld_q    <= {pipe_vld_q[LATENCY-1:0], |grant};
      pipe_tag_q[0] <= grant_idx;
      for (int unsigned i = 1; i <= LATENCY; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
    end
  end

  assign rsp_valid  = pipe_vld_q[LATENCY]
                      ? N_REQ'(onehot_of(3'(pipe_tag_q[LATENCY]))) : '0;
  assign rsp_data   = pipe_vld_q[LATENCY] ? alu_y : '0;
  assign flush_done = (state_q == DRAIN) & pipe_empty;
  assign busy       = (state_q != IDLE) | ~pipe_empty;

`ifdef V2F_ALU_SCHED_PERF_EN
  logic [31:0] perf_cnt_q [N_REQ];
  logic [31:0] conflict_q;
  logic        conflict_hit;

  assign conflict_hit = $countones(req_valid) > 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) perf_cnt_q[i] <= '0;
    end else if (flush_done) begin
      conflict_q <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) perf_cnt_q[i] <= '0;
    end else begin
      if (conflict_hit && conflict_q != '1) conflict_q <= conflict_q + 32'd1;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant[i] && perf_cnt_q[i] != '1) perf_cnt_q[i] <= perf_cnt_q[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_perf
    assign perf_grants[32*g +: 32] = perf_cnt_q[g];
  end
  assign perf_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_v2f_alu_sched.sv
// Self-checking bench for v2f_alu_sched: two instances (LATENCY 1 and 3)
// share stimulus; a cycle-level reference model predicts every output.
module tb_v2f_alu_sched;
  import v2f_sched_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int ND = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;

  logic [N-1:0]   rdy   [ND];
  logic           avld  [ND];
  logic [3:0]     aop   [ND];
  logic [W-1:0]   aa    [ND];
  logic [W-1:0]   ab    [ND];
  logic [W-1:0]   ay    [ND];
  logic [N-1:0]   rvld  [ND];
  logic [W-1:0]   rdat  [ND];
  logic           fdone [ND];
  logic           bsy   [ND];
`ifdef V2F_ALU_SCHED_PERF_EN
  logic [32*N-1:0] pg [ND];
  logic [31:0]     pc [ND];
`endif

  always #5 clk = ~clk;

  v2f_alu_sched #(.N_REQ(N), .LATENCY(1), .DATA_W(W)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(rdy[0]), .alu_valid(avld[0]),
    .alu_op(aop[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_y(ay[0]),
    .rsp_valid(rvld[0]), .rsp_data(rdat[0]), .flush(flush),
    .flush_done(fdone[0]), .busy(bsy[0])
`ifdef V2F_ALU_SCHED_PERF_EN
    , .perf_grants(pg[0]), .perf_conflict(pc[0])
`endif
  );

  v2f_alu_sched #(.N_REQ(N), .LATENCY(3), .DATA_W(W)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(rdy[1]), .alu_valid(avld[1]),
    .alu_op(aop[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_y(ay[1]),
    .rsp_valid(rvld[1]), .rsp_data(rdat[1]), .flush(flush),
    .flush_done(fdone[1]), .busy(bsy[1])
`ifdef V2F_ALU_SCHED_PERF_EN
    , .perf_grants(pg[1]), .perf_conflict(pc[1])
`endif
  );

  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (v2f_op_t'(op))
      ADD:     return a + b;
      SUB:     return a - b;
      MUL:     return a * b;
      DIV:     return (b == '0) ? '0 : a / b;
      MOD:     return (b == '0) ? '0 : a % b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SHL:     return a << b[4:0];
      SHR:     return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Behavioural shared unit: result appears LATENCY cycles after the issue cycle.
  logic [W-1:0] sr [ND][MAX_LATENCY];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < ND; d++)
        for (int j = 0; j < MAX_LATENCY; j++) sr[d][j] <= '0;
    end else begin
      for (int d = 0; d < ND; d++) begin
        sr[d][0] <= avld[d] ? alu_f(aop[d], aa[d], ab[d]) : '0;
        for (int j = 1; j < MAX_LATENCY; j++) sr[d][j] <= sr[d][j-1];
      end
    end
  end
  assign ay[0] = sr[0][0];
  assign ay[1] = sr[1][2];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [3:0]   s_op [N];
  logic [W-1:0] s_a  [N];
  logic [W-1:0] s_b  [N];

  // Reference model: mode 0 idle, 1 running, 2 draining; responses kept in a
  // ring indexed by the cycle they are due.
  int           m_mode [ND];
  int           m_ptr  [ND];
  logic         m_sv   [ND][16];
  int           m_st   [ND][16];
  logic [W-1:0] m_sd   [ND][16];
  logic         m_iv   [ND];
  logic [3:0]   m_iop  [ND];
  logic [W-1:0] m_ia   [ND];
  logic [W-1:0] m_ib   [ND];
  int           m_pg   [ND][N];
  int           m_pc   [ND];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic string tg(input int d, input string s);
    return $sformatf("L%0d_%s", lat_of(d), s);
  endfunction

  task automatic model_cycle(input int d, input logic [N-1:0] v, input logic fl, input logic r);
    int           lat;
    int           s;
    int           gi;
    int           idx;
    int           nv;
    logic         pe;
    logic         fd;
    logic [N-1:0] g;
    logic [N-1:0] ev;
    logic [W-1:0] ed;
    lat = lat_of(d);
    s   = cyc % 16;
    if (r) begin
      m_mode[d] = 0;
      m_ptr[d]  = 0;
      m_iv[d]   = 1'b0;
      m_pc[d]   = 0;
      for (int k = 0; k < 16; k++) m_sv[d][k] = 1'b0;
      for (int i = 0; i < N; i++) m_pg[d][i] = 0;
      check(tg(d, "rst_ready"), rdy[d], '0);
      check(tg(d, "rst_alu_valid"), avld[d], '0);
      check(tg(d, "rst_alu_op"), aop[d], '0);
      check(tg(d, "rst_alu_a"), aa[d], '0);
      check(tg(d, "rst_alu_b"), ab[d], '0);
      check(tg(d, "rst_rsp_valid"), rvld[d], '0);
      check(tg(d, "rst_rsp_data"), rdat[d], '0);
      check(tg(d, "rst_flush_done"), fdone[d], '0);
      check(tg(d, "rst_busy"), bsy[d], '0);
    end else begin
      pe = 1'b1;
      for (int k = 0; k <= lat; k++) if (m_sv[d][(cyc + k) % 16]) pe = 1'b0;
      ev = '0;
      ed = '0;
      if (m_sv[d][s]) begin
        ev[m_st[d][s]] = 1'b1;
        ed             = m_sd[d][s];
        m_sv[d][s]     = 1'b0;
      end
      g  = '0;
      gi = 0;
      if (m_mode[d] != 2 && !fl) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr[d] + k) % N;
          if (g == '0 && v[idx]) begin
            g[idx] = 1'b1;
            gi     = idx;
          end
        end
      end
      fd = (m_mode[d] == 2) && pe;

      check(tg(d, "ready"), rdy[d], g);
      check(tg(d, "alu_valid"), avld[d], m_iv[d]);
      if (m_iv[d]) begin
        check(tg(d, "alu_op"), aop[d], m_iop[d]);
        check(tg(d, "alu_a"), aa[d], m_ia[d]);
        check(tg(d, "alu_b"), ab[d], m_ib[d]);
      end
      check(tg(d, "rsp_valid"), rvld[d], ev);
      check(tg(d, "rsp_data"), rdat[d], ed);
      check(tg(d, "flush_done"), fdone[d], fd);
      check(tg(d, "busy"), bsy[d], (m_mode[d] != 0) || !pe);
`ifdef V2F_ALU_SCHED_PERF_EN
      for (int i = 0; i < N; i++) check(tg(d, "perf_grants"), pg[d][32*i +: 32], m_pg[d][i]);
      check(tg(d, "perf_conflict"), pc[d], m_pc[d]);
`endif

      nv = $countones(v);
      if (fd) begin
        m_pc[d] = 0;
        for (int i = 0; i < N; i++) m_pg[d][i] = 0;
      end else begin
        if (nv >= 2) m_pc[d]++;
        if (g != '0) m_pg[d][gi]++;
      end

      if (g != '0) begin
        m_sv[d][(cyc + 1 + lat) % 16] = 1'b1;
        m_st[d][(cyc + 1 + lat) % 16] = gi;
        m_sd[d][(cyc + 1 + lat) % 16] = alu_f(s_op[gi], s_a[gi], s_b[gi]);
        m_ptr[d] = (gi + 1) % N;
        m_iv[d]  = 1'b1;
        m_iop[d] = s_op[gi];
        m_ia[d]  = s_a[gi];
        m_ib[d]  = s_b[gi];
      end else begin
        m_iv[d] = 1'b0;
      end

      case (m_mode[d])
        0:       if (fl) m_mode[d] = 2; else if (nv != 0) m_mode[d] = 1;
        1:       if (fl) m_mode[d] = 2; else if (nv == 0 && pe) m_mode[d] = 0;
        default: if (pe) m_mode[d] = 0;
      endcase
    end
  endtask

  // Drive one cycle's inputs mid-cycle, check both DUTs, advance to next negedge.
  task automatic step(input logic [N-1:0] v, input logic fl, input logic r);
    for (int i = 0; i < N; i++) begin
      req_op[4*i +: 4] = s_op[i];
      req_a[W*i +: W]  = s_a[i];
      req_b[W*i +: W]  = s_b[i];
    end
    req_valid = v;
    flush     = fl;
    rst       = r;
    #1;
    for (int d = 0; d < ND; d++) model_cycle(d, v, fl, r);
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      s_op[i] = 4'($urandom_range(9));
      s_a[i]  = ($urandom_range(2) == 0) ? $urandom : W'($urandom_range(100));
      s_b[i]  = ($urandom_range(4) == 0) ? '0 : W'($urandom_range(40));
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      s_op[i] = '0;
      s_a[i]  = '0;
      s_b[i]  = '0;
    end
    @(negedge clk);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);

    // Single request: requester 2, ADD 5+7.
    s_op[2] = ADD; s_a[2] = 32'd5; s_b[2] = 32'd7;
    step(4'b0100, 1'b0, 1'b0);
    repeat (6) step('0, 1'b0, 1'b0);

    // Fairness from rr_ptr=0.
    step('0, 1'b0, 1'b1);
    rand_fields();
    repeat (8) step(4'b1111, 1'b0, 1'b0);
    repeat (6) step('0, 1'b0, 1'b0);

    // Back-to-back MUL 3*4 then DIV 9/0 from requester 1.
    s_op[1] = MUL; s_a[1] = 32'd3; s_b[1] = 32'd4;
    step(4'b0010, 1'b0, 1'b0);
    s_op[1] = DIV; s_a[1] = 32'd9; s_b[1] = 32'd0;
    step(4'b0010, 1'b0, 1'b0);
    repeat (7) step('0, 1'b0, 1'b0);

    // Flush with three ops in flight and all requesters valid.
    rand_fields();
    repeat (3) step(4'b0001, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    repeat (3) step(4'b1111, 1'b0, 1'b0);
    repeat (8) step('0, 1'b0, 1'b0);

    // Async reset with two tags in the pipe.
    rand_fields();
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    repeat (6) step('0, 1'b0, 1'b0);

    // Two requesters contending for 10 cycles, then flush clears counters.
    step('0, 1'b0, 1'b1);
    rand_fields();
    repeat (10) step(4'b0011, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    repeat (6) step('0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 600; t++) begin
      logic [N-1:0] v;
      logic         fl;
      logic         r;
      rand_fields();
      v  = N'($urandom);
      fl = ($urandom_range(24) == 0);
      r  = ($urandom_range(199) == 0);
      step(v, fl, r);
    end
    repeat (8) step('0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
